// File: rtl/fm_mod_gen2.sv
// FM/PM phase generator: offset-binary sample scaled by a deviation word steers a phase
// accumulator; three-stage datapath with carrier-only fallback when the sample stream stalls.
module fm_mod_gen2 #(
    parameter int INPUT_WIDTH  = 12,
    parameter int PHASE_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 12,
    parameter int DEV_WIDTH    = 20,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk_in,
    input  logic                    RST,
    input  logic [INPUT_WIDTH-1:0]  wave_in,
    input  logic                    wave_valid,
    input  logic                    cfg_load,
    input  logic [PHASE_WIDTH-1:0]  center_fre,
    input  logic [DEV_WIDTH-1:0]    move_fre,
    input  logic [1:0]              mode,
    output logic [PHASE_WIDTH-1:0]  freq_word,
    output logic [OUTPUT_WIDTH-1:0] phase_out,
    output logic                    ovr,
    output logic                    idle
);

    localparam int OFS_W = INPUT_WIDTH + DEV_WIDTH + 1;
    localparam int SUM_W = (OFS_W + 1 > PHASE_WIDTH + 2) ? OFS_W + 1 : PHASE_WIDTH + 2;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [1:0] MODE_PM = 2'd1;
    localparam logic [1:0] MODE_CW = 2'd2;
    localparam logic signed [SUM_W-1:0] FREQ_MAX =
        {{(SUM_W-PHASE_WIDTH){1'b0}}, {PHASE_WIDTH{1'b1}}};

    function automatic logic signed [SUM_W-1:0] sext_ofs(input logic signed [OFS_W-1:0] o);
        return {{(SUM_W-OFS_W){o[OFS_W-1]}}, o};
    endfunction

    // MSB is the saturation flag, the rest the clamped frequency word
    function automatic logic [PHASE_WIDTH:0] clamp_freq(input logic signed [SUM_W-1:0] s);
        if (s[SUM_W-1])
            return {1'b1, {PHASE_WIDTH{1'b0}}};
        else if (s > FREQ_MAX)
            return {1'b1, {PHASE_WIDTH{1'b1}}};
        else
            return {1'b0, s[PHASE_WIDTH-1:0]};
    endfunction

    logic [PHASE_WIDTH-1:0]          center_q, center_p_q;
    logic [DEV_WIDTH-1:0]            dev_q;
    logic [1:0]                      mode_q, mode_p_q;
    logic signed [INPUT_WIDTH-1:0]   sample_q;
    logic signed [OFS_W-1:0]         offset_q;
    logic [PHASE_WIDTH-1:0]          freq_q, pm_off_q, acc_q;
    logic [OUTPUT_WIDTH-1:0]         phase_q;
    logic                            ovr_q;
    logic [CNT_W-1:0]                idle_cnt_q;

    logic signed [OFS_W-1:0]         mul_a, mul_b, offset_d;
    logic signed [SUM_W-1:0]         ofs_ext, sum_d;
    logic [PHASE_WIDTH:0]            clamp_d;
    logic                            pm_mode, sat_d, ovr_d;
    logic [PHASE_WIDTH-1:0]          freq_d, pm_off_d;

    assign idle = (idle_cnt_q == CNT_MAX);

    // S2: full-width signed product, no truncation
    assign mul_a    = {{(OFS_W-INPUT_WIDTH){sample_q[INPUT_WIDTH-1]}}, sample_q};
    assign mul_b    = {{(OFS_W-DEV_WIDTH){1'b0}}, dev_q};
    assign offset_d = (mode_q == MODE_CW || idle) ? '0 : mul_a * mul_b;

    // S3: FM clamps into the unsigned word range; PM passes the offset to the phase path
    assign ofs_ext  = sext_ofs(offset_q);
    assign sum_d    = $signed({{(SUM_W-PHASE_WIDTH){1'b0}}, center_p_q}) + ofs_ext;
    assign clamp_d  = clamp_freq(sum_d);
    assign pm_mode  = (mode_p_q == MODE_PM);
    assign freq_d   = pm_mode ? center_p_q : clamp_d[PHASE_WIDTH-1:0];
    assign sat_d    = !pm_mode && clamp_d[PHASE_WIDTH];
    assign pm_off_d = pm_mode ? ofs_ext[PHASE_WIDTH-1:0] : '0;
    assign ovr_d    = sat_d | (ovr_q & ~cfg_load);

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            center_q   <= '0;
            dev_q      <= '0;
            mode_q     <= '0;
            sample_q   <= '0;
            idle_cnt_q <= '0;
            offset_q   <= '0;
            center_p_q <= '0;
            mode_p_q   <= '0;
            freq_q     <= '0;
            pm_off_q   <= '0;
            ovr_q      <= 1'b0;
            acc_q      <= '0;
            phase_q    <= '0;
        end else begin
            // S1: config capture, sample capture, stall detection
            if (cfg_load) begin
                center_q <= center_fre;
                dev_q    <= move_fre;
                mode_q   <= mode;
            end
            if (wave_valid) begin
                sample_q   <= $signed({~wave_in[INPUT_WIDTH-1], wave_in[INPUT_WIDTH-2:0]});
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != CNT_MAX) begin
                idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            end
            // S2: carrier and mode travel with the offset so config changes land together
            offset_q   <= offset_d;
            center_p_q <= center_q;
            mode_p_q   <= mode_q;
            // S3
            freq_q   <= freq_d;
            pm_off_q <= pm_off_d;
            ovr_q    <= ovr_d;
            // Phase accumulator wraps modulo 2^PHASE_WIDTH
            acc_q   <= acc_q + freq_q;
            phase_q <= OUTPUT_WIDTH'((acc_q + pm_off_q) >> (PHASE_WIDTH - OUTPUT_WIDTH));
        end
    end

    assign freq_word = freq_q;
    assign phase_out = phase_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_fm_mod_gen2.sv
// Directed bench for fm_mod_gen2: expected outputs are queued with their due cycle and
// checked on the falling edge when that cycle arrives.
module tb_fm_mod_gen2;

    localparam int T_OUT = 64;

    logic        clk_in = 1'b0;
    logic        RST;
    logic [11:0] wave_in;
    logic        wave_valid;
    logic        cfg_load;
    logic [31:0] center_fre;
    logic [19:0] move_fre;
    logic [1:0]  mode;
    logic [31:0] freq_word;
    logic [11:0] phase_out;
    logic        ovr;
    logic        idle;

    fm_mod_gen2 #(
        .INPUT_WIDTH(12), .PHASE_WIDTH(32), .OUTPUT_WIDTH(12), .DEV_WIDTH(20), .TIMEOUT(T_OUT)
    ) dut (
        .clk_in(clk_in), .RST(RST), .wave_in(wave_in), .wave_valid(wave_valid),
        .cfg_load(cfg_load), .center_fre(center_fre), .move_fre(move_fre), .mode(mode),
        .freq_word(freq_word), .phase_out(phase_out), .ovr(ovr), .idle(idle)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int unsigned at;
        int          kind;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t         sbq[$];
    sb_t         keep[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned b;
    int unsigned d;
    logic [31:0] act;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Scoreboard: pop entries whose cycle has arrived and compare against the DUT
    always @(negedge clk_in) begin
        keep.delete();
        foreach (sbq[i]) begin
            if (sbq[i].at == cyc) begin
                case (sbq[i].kind)
                    0: act = freq_word;
                    1: act = {20'd0, phase_out};
                    2: act = {31'd0, ovr};
                    default: act = {31'd0, idle};
                endcase
                n_cmp++;
                assert (act === sbq[i].exp) else begin
                    n_bad++;
                    $error("FAIL %s @%0d: observed %h expected %h", sbq[i].tag, cyc, act, sbq[i].exp);
                end
            end else if (sbq[i].at < cyc) begin
                n_cmp++;
                n_bad++;
                $error("FAIL %s: check for cycle %0d never evaluated", sbq[i].tag, sbq[i].at);
            end else begin
                keep.push_back(sbq[i]);
            end
        end
        sbq = keep;
    end

    function automatic logic [31:0] mfreq(longint c, longint dv, int md, int w, bit idl);
        longint off, sum;
        off = (md == 2 || idl) ? 64'sd0 : (longint'(w) - 2048) * dv;
        if (md == 1) return c[31:0];
        sum = c + off;
        if (sum < 0) return 32'd0;
        if (sum > 64'sh0_FFFF_FFFF) return 32'hFFFF_FFFF;
        return sum[31:0];
    endfunction

    function automatic logic [31:0] mphase(longint j, longint f, longint p);
        longint a;
        a = (j * f + p) & 64'sh0_FFFF_FFFF;
        return {20'd0, a[31:20]};
    endfunction

    task automatic push(int unsigned at, int kind, logic [31:0] e, string tag);
        sb_t x;
        x.at = at; x.kind = kind; x.exp = e; x.tag = tag;
        sbq.push_back(x);
    endtask

    task automatic issue(bit cfg, logic [31:0] c, logic [19:0] dv, logic [1:0] md,
                         bit vld, logic [11:0] w);
        cfg_load = cfg; center_fre = c; move_fre = dv; mode = md;
        wave_valid = vld; wave_in = w;
        b = cyc;
        @(negedge clk_in);
        cfg_load = 1'b0;
        wave_valid = 1'b0;
    endtask

    task automatic wait_until(int unsigned t);
        while (cyc < t) @(negedge clk_in);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL drain: %0d checks pending, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        RST = 1'b0;
    endtask

    task automatic check_zero(string tag);
        n_cmp++;
        assert (freq_word === 32'd0) else begin
            n_bad++; $error("FAIL %s freq_word: observed %h expected 0", tag, freq_word);
        end
        n_cmp++;
        assert (phase_out === 12'd0) else begin
            n_bad++; $error("FAIL %s phase_out: observed %h expected 0", tag, phase_out);
        end
        n_cmp++;
        assert (ovr === 1'b0) else begin
            n_bad++; $error("FAIL %s ovr: observed %b expected 0", tag, ovr);
        end
        n_cmp++;
        assert (idle === 1'b0) else begin
            n_bad++; $error("FAIL %s idle: observed %b expected 0", tag, idle);
        end
    endtask

    initial begin
        RST = 1'b1; wave_in = '0; wave_valid = 1'b0; cfg_load = 1'b0;
        center_fre = '0; move_fre = '0; mode = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        check_zero("reset");
        RST = 1'b0;

        // No config yet: a sample alone must not move freq_word
        issue(1'b0, 32'h0, 20'd0, 2'd0, 1'b1, 12'hFFF);
        for (int i = 1; i <= 5; i++) push(b + i, 0, 32'd0, "noconfig_freq");
        drain();

        // Carrier with midscale sample, phase stepping by a quarter turn
        do_reset();
        issue(1'b1, 32'h4000_0000, 20'd105, 2'd0, 1'b1, 12'h800);
        push(b + 2, 0, 32'd0, "fm_latency_early");
        push(b + 3, 0, 32'h4000_0000, "fm_mid_freq");
        for (int j = 0; j < 5; j++) push(b + 4 + j, 1, mphase(j, 32'h4000_0000, 0), "fm_phase");
        drain();

        // Positive and negative full-scale deviation
        issue(1'b0, 32'h4000_0000, 20'd105, 2'd0, 1'b1, 12'hFFF);
        push(b + 2, 0, 32'h4000_0000, "fm_pos_early");
        push(b + 3, 0, mfreq(32'h4000_0000, 105, 0, 12'hFFF, 0), "fm_pos_freq");
        drain();
        issue(1'b0, 32'h4000_0000, 20'd105, 2'd0, 1'b1, 12'h000);
        push(b + 3, 0, mfreq(32'h4000_0000, 105, 0, 12'h000, 0), "fm_neg_freq");
        push(b + 3, 2, 32'd0, "fm_neg_ovr");
        drain();

        // Upper clamp, sticky ovr, clear on cfg_load, lower clamp
        issue(1'b1, 32'hFFFF_FFF0, 20'd1, 2'd0, 1'b1, 12'hFFF);
        push(b + 2, 2, 32'd0, "sat_ovr_early");
        push(b + 3, 0, 32'hFFFF_FFFF, "sat_hi_freq");
        push(b + 3, 2, 32'd1, "sat_hi_ovr");
        push(b + 6, 2, 32'd1, "sat_sticky");
        drain();
        issue(1'b1, 32'h0000_0010, 20'd1, 2'd0, 1'b0, 12'h000);
        push(b + 1, 2, 32'd1, "sat_wins_clear");
        push(b + 3, 0, mfreq(32'h10, 1, 0, 12'hFFF, 0), "unsat_freq");
        push(b + 4, 2, 32'd1, "ovr_held");
        drain();
        issue(1'b1, 32'h0000_0010, 20'd1, 2'd0, 1'b0, 12'h000);
        push(b + 1, 2, 32'd0, "ovr_cleared");
        drain();
        issue(1'b0, 32'h0000_0010, 20'd1, 2'd0, 1'b1, 12'h000);
        push(b + 2, 2, 32'd0, "sat_lo_early");
        push(b + 3, 0, 32'd0, "sat_lo_freq");
        push(b + 3, 2, 32'd1, "sat_lo_ovr");
        drain();

        // Phase modulation from a known accumulator state
        do_reset();
        issue(1'b1, 32'h1000_0000, 20'h04000, 2'd1, 1'b1, 12'hC00);
        push(b + 3, 0, 32'h1000_0000, "pm_freq");
        for (int j = 0; j < 4; j++)
            push(b + 4 + j, 1, mphase(j, 32'h1000_0000, (longint'(12'hC00) - 2048) * 16384), "pm_phase");
        push(b + 5, 2, 32'd0, "pm_ovr");
        drain();

        // Carrier-only mode and mode 3 behaving as FM
        issue(1'b1, 32'h2000_0000, 20'd105, 2'd2, 1'b1, 12'hFFF);
        push(b + 3, 0, 32'h2000_0000, "cw_freq");
        drain();
        issue(1'b1, 32'h2000_0000, 20'd105, 2'd3, 1'b1, 12'h123);
        push(b + 3, 0, mfreq(32'h2000_0000, 105, 3, 12'h123, 0), "mode3_freq");
        drain();

        // Stalled sample stream falls back to the carrier, next sample restores deviation
        issue(1'b1, 32'h4000_0000, 20'd105, 2'd0, 1'b1, 12'hFFF);
        push(b + T_OUT, 3, 32'd0, "idle_before");
        push(b + T_OUT + 1, 3, 32'd1, "idle_set");
        push(b + T_OUT + 2, 0, mfreq(32'h4000_0000, 105, 0, 12'hFFF, 0), "idle_dev_held");
        push(b + T_OUT + 3, 0, 32'h4000_0000, "idle_carrier");
        wait_until(b + T_OUT + 4);
        issue(1'b0, 32'h4000_0000, 20'd105, 2'd0, 1'b1, 12'hFFF);
        d = b;
        push(d + 1, 3, 32'd0, "idle_clear");
        push(d + 2, 0, 32'h4000_0000, "resume_early");
        push(d + 3, 0, mfreq(32'h4000_0000, 105, 0, 12'hFFF, 0), "resume_freq");
        drain();

        // Asynchronous reset with a sample still in flight
        issue(1'b1, 32'hFFFF_FFF0, 20'd1, 2'd0, 1'b1, 12'hFFF);
        push(b + 3, 2, 32'd1, "pre_rst_ovr");
        drain();
        issue(1'b0, 32'hFFFF_FFF0, 20'd1, 2'd0, 1'b1, 12'hFFF);
        wait_until(b + 2);
        #2 RST = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk_in);
        @(negedge clk_in);
        RST = 1'b0;
        b = cyc;
        for (int i = 1; i <= 6; i++) push(b + i, 0, 32'd0, "post_rst_freq");
        push(b + 4, 1, 32'd0, "post_rst_phase");
        drain();
        issue(1'b1, 32'h4000_0000, 20'd105, 2'd0, 1'b0, 12'h000);
        push(b + 2, 0, 32'd0, "post_rst_cfg_early");
        push(b + 3, 0, 32'h4000_0000, "post_rst_no_stale");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
